// File: rtl/vga_draw_pkg.sv
// ============================================================================
// Module      : vga_draw_pkg
// Description : Shared state encoding and default widths for the VGA draw
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_draw_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_X_W       = 8;
    localparam int DEF_Y_W       = 7;
    localparam int DEF_COLOUR_W  = 3;
    localparam int DEF_BG_COLOUR = 0;

endpackage

`default_nettype wire

// File: rtl/vga_draw_arbiter_if.sv
// ============================================================================
// Module      : vga_draw_arbiter_if
// Description : Requester-side bus and VGA plot port of the draw arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_draw_arbiter_if
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W
) ();

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          erase;
    logic [NUM_REQ*X_W-1:0]      base_x;
    logic [NUM_REQ*Y_W-1:0]      base_y;
    logic [NUM_REQ*COLOUR_W-1:0] colour;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        busy;
    logic [X_W-1:0]              vga_x;
    logic [Y_W-1:0]              vga_y;
    logic [COLOUR_W-1:0]         vga_colour;
    logic                        vga_plot;

    modport master (
        output req, erase, base_x, base_y, colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, erase, base_x, base_y, colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

`default_nettype wire

// File: rtl/vga_draw_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin winner search, upward from ptr with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [PTR_W-1:0]   ptr,
    output logic      [NUM_REQ-1:0] onehot,
    output logic      [PTR_W-1:0]   idx,
    output logic                    any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
// ============================================================================
// Module      : vga_draw_arbiter
// Description : Round-robin sharing of the VGA plot port; scans one sprite box
//               per grant, one pixel per cycle, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int COLOUR_W  = DEF_COLOUR_W,
    parameter int SPRITE_W  = 10,
    parameter int SPRITE_H  = 10,
    parameter int BG_COLOUR = DEF_BG_COLOUR
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vga_draw_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int DY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    state_t              state, state_n;
    logic [PTR_W-1:0]    ptr, ptr_n, win, win_n;
    logic [X_W-1:0]      cap_x, cap_x_n, vx, vx_n;
    logic [Y_W-1:0]      cap_y, cap_y_n, vy, vy_n;
    logic [COLOUR_W-1:0] vcol, vcol_n;
    logic [DX_W-1:0]     dx, dx_n;
    logic [DY_W-1:0]     dy, dy_n;
    logic [NUM_REQ-1:0]  grant_q, grant_n, done_q, done_n;
    logic                busy_q, busy_n, plot_q, plot_n;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The first pixel is registered on the grant edge so it appears with grant.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        cap_x_n = cap_x;
        cap_y_n = cap_y;
        vx_n    = vx;
        vy_n    = vy;
        vcol_n  = vcol;
        dx_n    = dx;
        dy_n    = dy;
        grant_n = grant_q;
        done_n  = '0;
        busy_n  = busy_q;
        plot_n  = plot_q;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    state_n = S_SCAN;
                    win_n   = pick_idx;
                    grant_n = pick_onehot;
                    busy_n  = 1'b1;
                    plot_n  = 1'b1;
                    cap_x_n = bus.base_x[int'(pick_idx)*X_W +: X_W];
                    cap_y_n = bus.base_y[int'(pick_idx)*Y_W +: Y_W];
                    vcol_n  = bus.erase[pick_idx] ? COLOUR_W'(BG_COLOUR)
                                                  : bus.colour[int'(pick_idx)*COLOUR_W +: COLOUR_W];
                    dx_n    = '0;
                    dy_n    = '0;
                    vx_n    = cap_x_n;
                    vy_n    = cap_y_n;
                end
            end
            S_SCAN: begin
                if (dx == DX_W'(SPRITE_W-1) && dy == DY_W'(SPRITE_H-1)) begin
                    state_n = S_DONE;
                    plot_n  = 1'b0;
                    grant_n = '0;
                    done_n  = NUM_REQ'(1) << win;
                end else begin
                    if (dx == DX_W'(SPRITE_W-1)) begin
                        dx_n = '0;
                        dy_n = dy + DY_W'(1);
                    end else begin
                        dx_n = dx + DX_W'(1);
                    end
                    vx_n = cap_x + X_W'(dx_n);
                    vy_n = cap_y + Y_W'(dy_n);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                ptr_n   = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win     <= '0;
            cap_x   <= '0;
            cap_y   <= '0;
            vx      <= '0;
            vy      <= '0;
            vcol    <= '0;
            dx      <= '0;
            dy      <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            win     <= win_n;
            cap_x   <= cap_x_n;
            cap_y   <= cap_y_n;
            vx      <= vx_n;
            vy      <= vy_n;
            vcol    <= vcol_n;
            dx      <= dx_n;
            dy      <= dy_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            plot_q  <= plot_n;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.vga_x      = vx;
    assign bus.vga_y      = vy;
    assign bus.vga_colour = vcol;
    assign bus.vga_plot   = plot_q;

endmodule

`default_nettype wire

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
Shares the single VGA adapter plot port among up to NUM_REQ sprite controllers, such as the player movement FSM, bullet FSMs and enemy FSMs. Each requester asks for one sprite-box operation, either draw or erase, at a base coordinate. The arbiter grants requesters round-robin and scans the SPRITE_W x SPRITE_H box pixel by pixel onto the VGA port. When the box is finished it pulses done back to the granted requester. This replaces the per-FSM 0..99 draw counters and removes plot-port contention between sprites.

Parameters:
NUM_REQ, 4, number of requesters.
X_W, 8, VGA x coordinate width.
Y_W, 7, VGA y coordinate width.
COLOUR_W, 3, colour width.
SPRITE_W, 10, box width in pixels.
SPRITE_H, 10, box height in pixels.
BG_COLOUR, 0, colour written on erase.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester operation request, level
erase  in  NUM_REQ  1 = erase box, 0 = draw box
base_x  in  NUM_REQ*X_W  packed top-left x; requester i occupies slice [i*X_W +: X_W]
base_y  in  NUM_REQ*Y_W  packed top-left y
colour  in  NUM_REQ*COLOUR_W  packed draw colour
grant  out  NUM_REQ  one-hot; held for the whole scan
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
busy  out  1  high in SCAN and DONE
vga_x  out  X_W  plot x
vga_y  out  Y_W  plot y
vga_colour  out  COLOUR_W  plot colour
vga_plot  out  1  plot write enable

Behaviour:
- All outputs are registered. On reset, asynchronously: every output is 0, the state is IDLE, and the round-robin pointer is 0.
- Reset mid-scan aborts the scan with no done pulse. Pixels already plotted are left in place.
- State IDLE:
  - If any req bit is set, choose the winner: the first set bit searching upward from the pointer, wrapping at NUM_REQ.
  - Capture the winner's base_x, base_y and erase bit. Capture its colour, or BG_COLOUR if erase is set.
  - Register grant, clear dx and dy, go to SCAN.
  - If no req bit is set, stay in IDLE.
- State SCAN, one pixel per cycle:
  - vga_plot = 1.
  - vga_x = (cap_x + dx) mod 2^X_W; vga_y = (cap_y + dy) mod 2^Y_W. Coordinates wrap and are never saturated.
  - dx increments every cycle. When dx = SPRITE_W-1, dx resets to 0 and dy increments.
  - Scan order is row-major, starting at (0,0).
  - After the pixel (SPRITE_W-1, SPRITE_H-1) is plotted, go to DONE.
- State DONE:
  - done[winner] = 1 for this cycle only; vga_plot = 0; grant is cleared.
  - pointer <= winner+1, mod NUM_REQ.
  - Go to IDLE.
- Timing for grant asserted in cycle G:
  - Pixel k (0-based) is plotted in cycle G+k; the last pixel is in G+SPRITE_W*SPRITE_H-1.
  - done is in G+SPRITE_W*SPRITE_H.
  - IDLE is in the next cycle, and the earliest next grant follows it.
  - With defaults: first pixel at G, last at G+99, done at G+100, next grant at G+102.
- Inputs are sampled only in IDLE. Changes to base_x, base_y, colour, erase or req during SCAN are ignored. Dropping req mid-scan does not abort the scan.
- Requester obligation: deassert req no later than the cycle after done. A req still high in IDLE is treated as a new request.
- Fairness:
  - Simultaneous requests are served in round-robin order.
  - A continuously requesting source waits at most NUM_REQ-1 operations.
- Counter widths are $clog2(SPRITE_W) and $clog2(SPRITE_H), each at least 1. Additions are done in the X_W/Y_W widths, so the carry is dropped.

Decomposition:
- Shared package vga_draw_pkg holds: state encodings (S_IDLE, S_SCAN, S_DONE), default X_W, Y_W and COLOUR_W, and BG_COLOUR.
- One sub-module, rr_pick: combinational round-robin winner selection from req and pointer, producing a one-hot output plus an index.
- Scan counters and the output registers stay in the top module.

Test Plan:
1. Single requester: req = 0001, base (20,30), colour 3'b101, draw.
   - grant 0001 one cycle later.
   - 100 plots, (20,30) through (29,39) in row-major order, all colour 101.
   - done[0] at grant+100.
2. Erase: req[2], erase = 1, colour 3'b111.
   - All 100 plots carry BG_COLOUR 0; done[2] pulses exactly once.
3. Contention: req = 1111 held continuously, each requester dropping req the cycle after its done.
   - Grant order 0, 1, 2, 3.
   - Gap between consecutive grants is 102 cycles.
   - No overlap between grant bits; vga_plot is low in DONE and IDLE.
4. Wrap-around: base (250,125).
   - vga_x sequence 250..255 then 0..3; vga_y 125..127 then 0..6.
   - No spurious extra plots.
5. Input change mid-scan: change base_x to 0 and drop req at pixel 50.
   - Remaining pixels still use the captured base; done still pulses.
6. Reset at pixel 40 of a scan.
   - All outputs are 0 in the same cycle, no done pulse, pointer back to 0.
   - With req = 1010 after release, requester 1 is granted first.
